nes_video_scaler: RTL and testbench

NES_VIDEO_SCALER -- requirements
Module: nes_video_scaler

---
 rtl/nes_video_pkg.sv | 49 ++++
 rtl/nes_fb_ram.sv | 21 ++
 rtl/nes_video_scaler.sv | 174 +++++++++++++++++
 tb/tb_nes_video_scaler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_video_pkg.sv
// Shared constants, colour tables and FSM state type for the NES video scaler.
package nes_video_pkg;

    localparam int NES_W    = 256;
    localparam int NES_H    = 240;
    localparam int ACTIVE_W = 640;
    localparam int ACTIVE_H = 480;
    localparam int BAR_W    = 80;
    localparam int NUM_BARS = 8;

    // Coordinate value used by the VGA timing block when outside active video
    localparam logic [9:0] COORD_BLANK = 10'h3FF;

    typedef enum logic {
        NO_SIGNAL = 1'b0,
        LIVE      = 1'b1
    } state_t;

    // NES 2C02 palette, 24-bit {R, G, B}
    localparam logic [23:0] PALETTE [0:63] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC,
        24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800,
        24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC,
        24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844,
        24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8,
        24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898,
        24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8,
        24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8,
        24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // Palette indices of the no-signal colour bars, left to right
    localparam logic [5:0] TEST_BAR [0:NUM_BARS-1] = '{
        6'h30, 6'h28, 6'h2C, 6'h2A, 6'h24, 6'h16, 6'h12, 6'h0F
    };

    // Widen an 8-bit channel to 10 bits by replicating its top bits
    function automatic logic [9:0] expand_channel(input logic [7:0] c);
        return {c, c[7:6]};
    endfunction

endpackage

// File: rtl/nes_fb_ram.sv
// 64K x 6 simple dual-port framebuffer: one write port, one registered read port.
module nes_fb_ram (
    input  logic        clock,
    input  logic        write_en,
    input  logic [15:0] write_addr,
    input  logic [5:0]  write_data,
    input  logic [15:0] read_addr,
    output logic [5:0]  read_data
);

    logic [5:0] mem [0:65535];

    // Write and read share one edge; the non-blocking read returns the pre-write value on collision
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
        read_data <= mem[read_addr];
    end

endmodule

// File: rtl/nes_video_scaler.sv
// Scales the 256x240 NES picture 2x into a 640x480 VGA raster, falling back to colour bars without a PPU.
module nes_video_scaler
    import nes_video_pkg::*;
#(
    parameter int H_OFFSET       = 64,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pix_valid,
    input  logic [7:0] pix_x,
    input  logic [7:0] pix_y,
    input  logic [5:0] pix_index,
    input  logic       ppu_frame_start,
    input  logic [9:0] x_addr,
    input  logic [9:0] y_addr,
    output logic [9:0] vga_r,
    output logic [9:0] vga_g,
    output logic [9:0] vga_b,
    output logic       live
);

    localparam int CNT_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

    // Write side
    logic        fb_we;
    logic [15:0] fb_waddr;

    // Read side, combinational address
    logic        in_window;
    logic [7:0]  read_col;
    logic [7:0]  read_row;
    logic [15:0] fb_raddr;
    logic [5:0]  fb_rdata;

    // Test pattern, combinational
    logic [2:0]  bar_sel;
    logic        pattern_valid;

    // Registered alongside the framebuffer read
    logic        window_q;
    logic        pattern_valid_q;
    logic [5:0]  pattern_index_q;
    state_t      mode_q;

    // Frame supervision
    state_t            state;
    logic [CNT_W-1:0]  frame_count;
    logic [9:0]        y_prev;
    logic              frame_edge;

    // Output colour path
    logic [5:0]  out_index;
    logic        out_visible;
    logic [23:0] out_rgb;

    // PPU pixels land directly at {row, col}; rows past the visible area and writes during reset are dropped
    always_comb begin
        fb_we    = pix_valid && !reset && (pix_y < 8'(NES_H));
        fb_waddr = {pix_y, pix_x};
    end

    // Map the VGA coordinate into the source image with 2x2 replication
    always_comb begin
        in_window = ({1'b0, x_addr} >= 11'(H_OFFSET))
                 && ({1'b0, x_addr} <  11'(H_OFFSET + 2 * NES_W))
                 && (y_addr < 10'(ACTIVE_H));
        read_col  = 8'((x_addr - 10'(H_OFFSET)) >> 1);
        read_row  = 8'(y_addr >> 1);
        fb_raddr  = {read_row, read_col};
    end

    // Pick the colour bar under the current column
    always_comb begin
        bar_sel = '0;
        for (int i = 1; i < NUM_BARS; i++) begin
            if (x_addr >= 10'(i * BAR_W)) begin
                bar_sel = 3'(i);
            end
        end
        pattern_valid = (x_addr < 10'(ACTIVE_W)) && (y_addr < 10'(ACTIVE_H));
    end

    nes_fb_ram u_fb_ram (
        .clock      (clock),
        .write_en   (fb_we),
        .write_addr (fb_waddr),
        .write_data (pix_index),
        .read_addr  (fb_raddr),
        .read_data  (fb_rdata)
    );

    // Pipeline the window flag, pattern index and mode so they line up with the RAM read data
    always_ff @(posedge clock) begin
        if (reset) begin
            window_q        <= 1'b0;
            pattern_valid_q <= 1'b0;
            pattern_index_q <= '0;
            mode_q          <= NO_SIGNAL;
        end else begin
            window_q        <= in_window;
            pattern_valid_q <= pattern_valid;
            pattern_index_q <= TEST_BAR[bar_sel];
            mode_q          <= state;
        end
    end

    // A VGA frame ends when the row leaves active video for blanking
    always_comb begin
        frame_edge = (y_prev < 10'(ACTIVE_H)) && (y_addr == COORD_BLANK);
    end

    // Keep the previous row to spot the end of each VGA frame
    always_ff @(posedge clock) begin
        if (reset) begin
            y_prev <= COORD_BLANK;
        end else begin
            y_prev <= y_addr;
        end
    end

    // Track PPU presence: go live on a frame start, fall back after too many silent VGA frames
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= NO_SIGNAL;
            frame_count <= '0;
            live        <= 1'b0;
        end else begin
            case (state)
                NO_SIGNAL: begin
                    if (ppu_frame_start) begin
                        state       <= LIVE;
                        frame_count <= '0;
                        live        <= 1'b1;
                    end
                end
                LIVE: begin
                    if (ppu_frame_start) begin
                        frame_count <= '0;
                    end else if (frame_edge) begin
                        if (frame_count == CNT_W'(TIMEOUT_FRAMES - 1)) begin
                            state       <= NO_SIGNAL;
                            frame_count <= '0;
                            live        <= 1'b0;
                        end else begin
                            frame_count <= frame_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= NO_SIGNAL;
                    frame_count <= '0;
                    live        <= 1'b0;
                end
            endcase
        end
    end

    // Colour lookup from the registered stage, blanked outside the visible area
    always_comb begin
        out_index   = (mode_q == LIVE) ? fb_rdata : pattern_index_q;
        out_visible = (mode_q == LIVE) ? window_q : pattern_valid_q;
        out_rgb     = PALETTE[out_index];
        vga_r       = '0;
        vga_g       = '0;
        vga_b       = '0;
        if (out_visible) begin
            vga_r = expand_channel(out_rgb[23:16]);
            vga_g = expand_channel(out_rgb[15:8]);
            vga_b = expand_channel(out_rgb[7:0]);
        end
    end

endmodule

// File: tb/tb_nes_video_scaler.sv
// Directed self-checking bench for nes_video_scaler.
module tb_nes_video_scaler;

    logic       clock;
    logic       reset;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic [5:0] pix_index;
    logic       ppu_frame_start;
    logic [9:0] x_addr;
    logic [9:0] y_addr;
    logic [9:0] vga_r;
    logic [9:0] vga_g;
    logic [9:0] vga_b;
    logic       live;

    int vectors;
    int miscompares;

    // Hand-copied 2C02 colours used by the directed steps
    localparam logic [23:0] C_30 = 24'hFCFCFC;
    localparam logic [23:0] C_28 = 24'hF8B800;
    localparam logic [23:0] C_24 = 24'hF878F8;
    localparam logic [23:0] C_16 = 24'hF83800;
    localparam logic [23:0] C_05 = 24'hA80020;
    localparam logic [23:0] C_2A = 24'h58D854;
    localparam logic [23:0] C_BLACK = 24'h000000;

    nes_video_scaler #(
        .H_OFFSET       (64),
        .TIMEOUT_FRAMES (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pix_valid       (pix_valid),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_index       (pix_index),
        .ppu_frame_start (ppu_frame_start),
        .x_addr          (x_addr),
        .y_addr          (y_addr),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .live            (live)
    );

    // 50 MHz clock
    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [29:0] expand_rgb(input logic [23:0] c);
        return {c[23:16], c[23:22], c[15:8], c[15:14], c[7:0], c[7:6]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [9:0] x, input logic [9:0] y);
        x_addr = x;
        y_addr = y;
        tick();
    endtask

    task automatic check_output(input string tag, input logic [23:0] colour);
        logic [29:0] observed;
        logic [29:0] expected;
        observed = {vga_r, vga_g, vga_b};
        expected = expand_rgb(colour);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed rgb=%h expected rgb=%h", tag, observed, expected);
        end
    endtask

    task automatic check_live(input string tag, input logic expected);
        vectors++;
        assert (live === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed live=%b expected live=%b", tag, live, expected);
        end
    endtask

    task automatic write_pixel(input logic [7:0] x, input logic [7:0] y, input logic [5:0] idx);
        pix_x     = x;
        pix_y     = y;
        pix_index = idx;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic pulse_frame_start();
        ppu_frame_start = 1'b1;
        tick();
        ppu_frame_start = 1'b0;
    endtask

    task automatic vga_frame_edge();
        y_addr = 10'h3FF;
        tick();
        y_addr = 10'd0;
        tick();
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        pix_valid       = 1'b0;
        pix_x           = '0;
        pix_y           = '0;
        pix_index       = '0;
        ppu_frame_start = 1'b0;
        x_addr          = 10'h3FF;
        y_addr          = 10'h3FF;
        tick();
        tick();

        // Reset state with an in-range coordinate presented
        apply_stimulus(10'd0, 10'd0);
        check_output("reset_rgb", C_BLACK);
        check_live("reset_live", 1'b0);

        // Test pattern bars and one-cycle latency
        reset = 1'b0;
        apply_stimulus(10'd0, 10'd0);
        check_output("bar0", C_30);
        check_live("nosig_live", 1'b0);
        x_addr = 10'd80;
        check_output("bar_latency_hold", C_30);
        tick();
        check_output("bar1", C_28);
        apply_stimulus(10'd320, 10'd479);
        check_output("bar4", C_24);
        apply_stimulus(10'd79, 10'h3FF);
        check_output("bar_blank_y", C_BLACK);

        // Load framebuffer while still in NO_SIGNAL, then go live
        write_pixel(8'd0, 8'd0, 6'h16);
        write_pixel(8'd1, 8'd0, 6'h05);
        write_pixel(8'd0, 8'd1, 6'h2A);
        apply_stimulus(10'd64, 10'd0);
        pulse_frame_start();
        check_live("went_live", 1'b1);

        // 2x2 replication and window edges
        apply_stimulus(10'd64, 10'd0);
        check_output("rep_64_0", C_16);
        apply_stimulus(10'd65, 10'd0);
        check_output("rep_65_0", C_16);
        apply_stimulus(10'd64, 10'd1);
        check_output("rep_64_1", C_16);
        apply_stimulus(10'd65, 10'd1);
        check_output("rep_65_1", C_16);
        apply_stimulus(10'd66, 10'd0);
        check_output("col1_row0", C_05);
        apply_stimulus(10'd64, 10'd2);
        check_output("col0_row1", C_2A);
        apply_stimulus(10'd63, 10'd0);
        check_output("left_border", C_BLACK);
        apply_stimulus(10'd576, 10'd0);
        check_output("right_border", C_BLACK);
        apply_stimulus(10'd100, 10'h3FF);
        check_output("live_blank_y", C_BLACK);
        apply_stimulus(10'd64, 10'd0);

        // Row 240 write ignored; known pixels intact
        write_pixel(8'd0, 8'd240, 6'h21);
        apply_stimulus(10'd64, 10'd0);
        check_output("sweep_0_0", C_16);
        apply_stimulus(10'd66, 10'd0);
        check_output("sweep_1_0", C_05);
        apply_stimulus(10'd64, 10'd2);
        check_output("sweep_0_1", C_2A);

        // Read and write the same location in one cycle
        x_addr    = 10'd66;
        y_addr    = 10'd0;
        write_pixel(8'd1, 8'd0, 6'h2A);
        check_output("collision_old", C_05);
        tick();
        check_output("collision_new", C_2A);

        // Mid-frame reset with a write that must be discarded
        apply_stimulus(10'd64, 10'd0);
        reset = 1'b1;
        write_pixel(8'd0, 8'd0, 6'h12);
        check_live("midreset_live", 1'b0);
        check_output("midreset_rgb", C_BLACK);
        reset = 1'b0;
        apply_stimulus(10'd64, 10'd0);
        check_output("after_reset_pattern", C_30);
        pulse_frame_start();
        apply_stimulus(10'd64, 10'd0);
        check_output("fb_kept", C_16);

        // Timeout with a rescue pulse after the third edge
        vga_frame_edge();
        vga_frame_edge();
        vga_frame_edge();
        check_live("edge3_live", 1'b1);
        pulse_frame_start();
        vga_frame_edge();
        vga_frame_edge();
        vga_frame_edge();
        check_live("rescued_edge3", 1'b1);
        vga_frame_edge();
        check_live("timeout_drop", 1'b0);
        apply_stimulus(10'd80, 10'd0);
        check_output("timeout_pattern", C_28);

        // Frame start coincident with the fourth edge keeps live and clears the count
        pulse_frame_start();
        check_live("relive", 1'b1);
        vga_frame_edge();
        vga_frame_edge();
        vga_frame_edge();
        y_addr          = 10'h3FF;
        ppu_frame_start = 1'b1;
        tick();
        ppu_frame_start = 1'b0;
        y_addr          = 10'd0;
        tick();
        check_live("coincident_live", 1'b1);
        vga_frame_edge();
        vga_frame_edge();
        vga_frame_edge();
        check_live("count_cleared", 1'b1);
        vga_frame_edge();
        check_live("final_drop", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
